// File: rtl/led_beat_monitor.sv
// Receive-side checker for the LED heartbeat: synchronises the beat line, times the
// rising edges and locks onto the PULSES-per-frame cadence, flagging early/late pulses.
module led_beat_monitor #(
  parameter int unsigned PULSE_GAP   = 31250000,
  parameter int unsigned FRAME_LEN   = 536870912,
  parameter int unsigned PULSES      = 3,
  parameter int unsigned TOL         = 1024,
  parameter int unsigned LOCK_FRAMES = 2,
  parameter int unsigned CNT_W       = 30
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        beat_in,
  output logic        alive,
  output logic        beat_seen,
  output logic        err_pulse,
  output logic [1:0]  err_code,
  output logic [15:0] err_count
);

  localparam int unsigned LONG_GAP_I = FRAME_LEN - (PULSES - 1) * PULSE_GAP;

  localparam logic [CNT_W-1:0] LONG_LO  = CNT_W'(LONG_GAP_I - TOL);
  localparam logic [CNT_W-1:0] LONG_HI  = CNT_W'(LONG_GAP_I + TOL);
  localparam logic [CNT_W-1:0] LONG_TO  = CNT_W'(LONG_GAP_I + TOL + 1);
  localparam logic [CNT_W-1:0] SHORT_LO = CNT_W'(PULSE_GAP - TOL);
  localparam logic [CNT_W-1:0] SHORT_TO = CNT_W'(PULSE_GAP + TOL + 1);

  localparam int IDX_W  = (PULSES > 1) ? $clog2(PULSES) : 1;
  localparam int GOOD_W = $clog2(LOCK_FRAMES + 1);

  localparam logic [IDX_W-1:0]  IDX_LAST = IDX_W'(PULSES - 1);
  localparam logic [GOOD_W-1:0] GOOD_MAX = GOOD_W'(LOCK_FRAMES);

  localparam logic [1:0] CODE_NONE  = 2'b00;
  localparam logic [1:0] CODE_EARLY = 2'b01;
  localparam logic [1:0] CODE_LATE  = 2'b10;

  typedef enum logic [1:0] {
    ST_SEARCH,
    ST_MEASURE,
    ST_TRACK
  } state_t;

  function automatic logic [CNT_W-1:0] cnt_inc_sat(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  function automatic logic [15:0] err_inc_sat(input logic [15:0] v);
    return (&v) ? v : v + 16'd1;
  endfunction

  function automatic logic [GOOD_W-1:0] good_inc_sat(input logic [GOOD_W-1:0] v);
    return (v >= GOOD_MAX) ? v : v + GOOD_W'(1);
  endfunction

  function automatic logic in_win(input logic [CNT_W-1:0] v,
                                  input logic [CNT_W-1:0] lo,
                                  input logic [CNT_W-1:0] hi);
    return (v >= lo) && (v <= hi);
  endfunction

  state_t             state_q, state_d;
  logic               sync1_q, sync2_q, prev_q;
  logic [CNT_W-1:0]   gap_cnt_q, gap_cnt_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [GOOD_W-1:0]  good_q, good_d;
  logic               alive_q, alive_d;
  logic               beat_seen_q;
  logic               err_pulse_q, err_pulse_d;
  logic [1:0]         err_code_q, err_code_d;
  logic [15:0]        err_count_q, err_count_d;

  logic               edge_det;
  logic [CNT_W-1:0]   exp_lo, exp_to;
  logic [1:0]         fault_code;

  // Edge detect on the synchronised line; gap_cnt_q at this point is the measured interval
  assign edge_det = sync2_q & ~prev_q;
  assign exp_lo   = (idx_q == '0) ? LONG_LO : SHORT_LO;
  assign exp_to   = (idx_q == '0) ? LONG_TO : SHORT_TO;

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    good_d      = good_q;
    alive_d     = alive_q;
    err_pulse_d = 1'b0;
    err_code_d  = err_code_q;
    err_count_d = err_count_q;
    fault_code  = CODE_NONE;
    gap_cnt_d   = edge_det ? CNT_W'(1) : cnt_inc_sat(gap_cnt_q);

    case (state_q)
      ST_SEARCH: begin
        if (edge_det) state_d = ST_MEASURE;
      end
      ST_MEASURE: begin
        if (edge_det) begin
          if (in_win(gap_cnt_q, LONG_LO, LONG_HI)) begin
            state_d = ST_TRACK;
            idx_d   = IDX_W'(1);
            good_d  = '0;
          end
        end else if (gap_cnt_q > LONG_HI) begin
          state_d = ST_SEARCH;
        end
      end
      ST_TRACK: begin
        // A timeout outranks a coincident edge; that edge then restarts acquisition
        if (gap_cnt_q >= exp_to) begin
          fault_code = CODE_LATE;
          state_d    = edge_det ? ST_MEASURE : ST_SEARCH;
        end else if (edge_det) begin
          if (gap_cnt_q < exp_lo) begin
            fault_code = CODE_EARLY;
            state_d    = ST_SEARCH;
          end else begin
            idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + IDX_W'(1);
            if (idx_q == '0) begin
              good_d = good_inc_sat(good_q);
              if (good_d >= GOOD_MAX) alive_d = 1'b1;
            end
          end
        end
      end
      default: state_d = ST_SEARCH;
    endcase

    if (fault_code != CODE_NONE) begin
      alive_d     = 1'b0;
      good_d      = '0;
      err_pulse_d = 1'b1;
      err_code_d  = fault_code;
      err_count_d = err_inc_sat(err_count_q);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_SEARCH;
      sync1_q     <= 1'b0;
      sync2_q     <= 1'b0;
      prev_q      <= 1'b0;
      gap_cnt_q   <= '0;
      idx_q       <= '0;
      good_q      <= '0;
      alive_q     <= 1'b0;
      beat_seen_q <= 1'b0;
      err_pulse_q <= 1'b0;
      err_code_q  <= CODE_NONE;
      err_count_q <= '0;
    end else begin
      state_q     <= state_d;
      sync1_q     <= beat_in;
      sync2_q     <= sync1_q;
      prev_q      <= sync2_q;
      gap_cnt_q   <= gap_cnt_d;
      idx_q       <= idx_d;
      good_q      <= good_d;
      alive_q     <= alive_d;
      beat_seen_q <= edge_det;
      err_pulse_q <= err_pulse_d;
      err_code_q  <= err_code_d;
      err_count_q <= err_count_d;
    end
  end

  assign alive     = alive_q;
  assign beat_seen = beat_seen_q;
  assign err_pulse = err_pulse_q;
  assign err_code  = err_code_q;
  assign err_count = err_count_q;

endmodule

// File: tb/tb_led_beat_monitor.sv
// Scoreboard bench for led_beat_monitor: an interval-level model predicts each
// beat_seen / err_pulse event (cycle and status) and the monitor checks them in order.
module tb_led_beat_monitor;

  localparam int PG  = 100;
  localparam int FL  = 512;
  localparam int NP  = 3;
  localparam int TOL = 4;
  localparam int LF  = 2;
  localparam int LG  = FL - (NP - 1) * PG;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        beat_in = 1'b0;
  logic        alive, beat_seen, err_pulse;
  logic [1:0]  err_code;
  logic [15:0] err_count;

  led_beat_monitor #(
    .PULSE_GAP(PG), .FRAME_LEN(FL), .PULSES(NP), .TOL(TOL),
    .LOCK_FRAMES(LF), .CNT_W(16)
  ) dut (
    .clk(clk), .rst_n(rst_n), .beat_in(beat_in), .alive(alive),
    .beat_seen(beat_seen), .err_pulse(err_pulse), .err_code(err_code),
    .err_count(err_count)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int       t;
    bit       bs;
    bit       ep;
    bit       al;
    bit [1:0] code;
    int       cnt;
  } ev_t;

  ev_t exp_q[$];
  int  n_cmp = 0;
  int  n_bad = 0;

  task automatic chk(input string tag, input longint got, input longint want);
    n_cmp++;
    if (got != want) begin
      n_bad++;
      $display("FAIL %s: got %0d, want %0d (cycle %0d)", tag, got, want, cyc);
    end
  endtask

  // Interval-level reference state
  int  m_st, m_idx, m_good, m_code, m_cnt, m_prev_seen, rise_cyc, ph;
  bit  m_alive, m_first;
  logic [18:0] held;
  int  seen_n, lock_edge;

  task automatic mdl_clear();
    m_st = 0; m_idx = 0; m_good = 0; m_code = 0; m_cnt = 0;
    m_alive = 1'b0; m_first = 1'b1; m_prev_seen = 0; ph = 0;
  endtask

  task automatic push(input int t, input bit bs, input bit ep);
    ev_t e;
    e.t = t; e.bs = bs; e.ep = ep; e.al = m_alive;
    e.code = 2'(m_code); e.cnt = m_cnt;
    exp_q.push_back(e);
  endtask

  task automatic mdl_fault(input int code);
    m_alive = 1'b0; m_good = 0; m_code = code;
    if (m_cnt < 65535) m_cnt++;
  endtask

  task automatic mdl_edge(input int g, input int seen_t);
    int expv, to;
    bit ep;
    ep = 1'b0;
    if (m_st == 0) begin
      m_st = 1;
    end else if (m_st == 1) begin
      if (g >= LG - TOL && g <= LG + TOL) begin
        m_st = 2; m_idx = 1; m_good = 0;
      end
    end else begin
      expv = (m_idx == 0) ? LG : PG;
      to   = expv + TOL + 1;
      if (g >= to) begin
        mdl_fault(2);
        if (g > to) push(m_prev_seen + to, 1'b0, 1'b1);
        else ep = 1'b1;
        m_st = 1;
      end else if (g < expv - TOL) begin
        mdl_fault(1);
        ep = 1'b1;
        m_st = 0;
      end else begin
        if (m_idx == 0) begin
          if (m_good < LF) m_good++;
          if (m_good >= LF) m_alive = 1'b1;
        end
        m_idx = (m_idx + 1) % NP;
      end
    end
    push(seen_t, 1'b1, ep);
    m_prev_seen = seen_t;
  endtask

  // Raise beat_in g cycles after the previous rise, holding it high for w cycles
  task automatic beat(input int g, input int w);
    int target;
    target = m_first ? cyc : rise_cyc + g;
    mdl_edge(m_first ? 0 : g, target + 3);
    m_first = 1'b0;
    while (cyc < target) begin
      @(posedge clk); #1;
    end
    beat_in = 1'b1;
    rise_cyc = target;
    repeat (w) begin
      @(posedge clk); #1;
    end
    beat_in = 1'b0;
  endtask

  task automatic run(input int n, input int w);
    for (int i = 0; i < n; i++) begin
      beat((ph == 2) ? LG : PG, w);
      ph = (ph + 1) % 3;
    end
  endtask

  task automatic drain();
    int k;
    k = 0;
    while (exp_q.size() != 0 && k < 60) begin
      @(posedge clk); #1;
      k++;
    end
    chk("drain", exp_q.size(), 0);
    exp_q.delete();
  endtask

  task automatic do_reset();
    drain();
    rst_n = 1'b0;
    held = '0; seen_n = 0; lock_edge = 0;
    mdl_clear();
    #2;
    chk("rst_async", longint'({alive, beat_seen, err_pulse, err_code, err_count}), 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  always @(negedge clk) begin : mon
    ev_t r;
    if (rst_n) begin
      if (beat_seen || err_pulse) begin
        if (exp_q.size() == 0) begin
          chk("extra_evt", longint'({beat_seen, err_pulse}), 0);
        end else begin
          r = exp_q.pop_front();
          chk("evt_cyc", cyc, r.t);
          chk("evt_flags", longint'({beat_seen, err_pulse}), longint'({r.bs, r.ep}));
          chk("evt_alive", longint'(alive), longint'(r.al));
          chk("evt_code", longint'(err_code), longint'(r.code));
          chk("evt_count", longint'(err_count), r.cnt);
          held = {r.al, r.code, 16'(r.cnt)};
        end
        if (beat_seen) begin
          seen_n++;
          if (alive && lock_edge == 0) lock_edge = seen_n;
        end
      end else begin
        chk("hold", longint'({alive, err_code, err_count}), longint'(held));
      end
    end
  end

  initial begin
    repeat (100000) @(posedge clk);
    $display("FAIL watchdog: cycle budget exhausted at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    mdl_clear();
    held = '0; seen_n = 0; lock_edge = 0; rise_cyc = 0;
    #1 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_init", longint'({alive, beat_seen, err_pulse, err_code, err_count}), 0);
    rst_n = 1'b1;

    // Clean acquisition
    beat(0, 1);
    run(12, 1);
    drain();
    chk("s1_lock_edge", lock_edge, 10);
    chk("s1_err_count", err_count, 0);

    // Early intra-frame pulse, then relock
    beat(90, 1);
    drain();
    chk("s2_code", err_code, 1);
    chk("s2_count", err_count, 1);
    chk("s2_alive_drop", alive, 0);
    run(9, 1);
    drain();
    chk("s2_relock", alive, 1);

    // Missing pulse -> late timeout, edge afterwards re-enters MEASURE
    beat(200, 1);
    drain();
    chk("s3_code", err_code, 2);
    chk("s3_count", err_count, 2);
    ph = 2;
    run(7, 1);
    drain();
    chk("s3_relock", alive, 1);

    // Window boundaries: 96/104 accepted, 95 early
    beat(96, 1);
    beat(104, 1);
    ph = 2;
    run(1, 1);
    drain();
    chk("s4_bound_alive", alive, 1);
    beat(95, 1);
    drain();
    chk("s4_early_code", err_code, 1);
    run(9, 1);
    drain();
    chk("s4_relock", alive, 1);
    chk("pre_rst_count", err_count, 3);

    // Reset while locked, then re-acquire
    do_reset();
    beat(0, 1);
    run(9, 1);
    drain();
    chk("s6_lock_edge", lock_edge, 10);
    chk("s6_err_count", err_count, 0);

    // Edge lands on the timeout cycle: one late fault, MEASURE keeps the edge
    beat(PG + TOL + 1, 1);
    drain();
    chk("s5_code", err_code, 2);
    chk("s5_count", err_count, 1);
    ph = 1;
    run(8, 1);
    drain();
    chk("s5_relock", alive, 1);

    // Long-held beat line still gives a single event per rise
    run(3, 60);
    drain();
    chk("held_alive", alive, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
